// File: rtl/bcam_mbist_outhandler.sv
// BCAM MBIST response handler: aligns issued expectations with the returned match vector and
// reports fail pulse, sticky fail, saturating count and first-fail diagnostics.
// Optional macro BCAM_MBIST_FAIL_VEC_CAPTURE_EN builds the first-fail difference vector register.
module bcam_mbist_outhandler #(
    parameter int  RF_ENTRIES = 64,
    parameter int  CM_LATENCY = 2,
    parameter int  FAIL_CNT_W = 8,
    localparam int ENTRY_AW   = $clog2(RF_ENTRIES)
) (
    input  logic                  bist_clk,
    input  logic                  rst,
    input  logic                  BIST_CM_MODE_RF_IN,
    input  logic                  BIST_CM_EN_RF_IN,
    input  logic                  BIST_CM_EXP_HIT_RF_IN,
    input  logic [ENTRY_AW-1:0]   BIST_CM_EXP_ENTRY_RF_IN,
    input  logic [RF_ENTRIES-1:0] CM_MATCH_RF_OUT_P0,
    input  logic                  BIST_CM_CLEAR_RF_IN,
    output logic                  BIST_CM_FAIL_RF_OUT,
    output logic                  BIST_CM_FAIL_STICKY_RF_OUT,
    output logic [FAIL_CNT_W-1:0] BIST_CM_FAIL_CNT_RF_OUT,
    output logic                  BIST_CM_FIRST_FAIL_VLD_RF_OUT,
    output logic [ENTRY_AW-1:0]   BIST_CM_FIRST_FAIL_ENTRY_RF_OUT,
    output logic [1:0]            BIST_CM_FIRST_FAIL_TYPE_RF_OUT,
    output logic                  BIST_CM_BUSY_RF_OUT,
    output logic [RF_ENTRIES-1:0] BIST_CM_FAIL_VEC_RF_OUT
);

    localparam logic [FAIL_CNT_W-1:0] CNT_MAX = '1;

    // Expectation pipeline; the last stage lines up with the match vector of its compare.
    logic [CM_LATENCY-1:0] pipe_vld_q;
    logic [CM_LATENCY-1:0] pipe_hit_q;
    logic [ENTRY_AW-1:0]   pipe_ent_q [CM_LATENCY];

    logic                  fail_q, out_vld_q, sticky_q, ff_vld_q;
    logic                  sticky_d, ff_vld_d;
    logic [FAIL_CNT_W-1:0] cnt_q, cnt_d;
    logic [ENTRY_AW-1:0]   ff_ent_q, ff_ent_d;
    logic [1:0]            ff_type_q, ff_type_d;

    logic                  vld_l, hit_l;
    logic [ENTRY_AW-1:0]   ent_l;
    logic [RF_ENTRIES-1:0] exp_vec, diff;
    logic                  miss_err, extra_err, mismatch;

    assign vld_l = pipe_vld_q[CM_LATENCY-1];
    assign hit_l = pipe_hit_q[CM_LATENCY-1];
    assign ent_l = pipe_ent_q[CM_LATENCY-1];

    always_comb begin
        exp_vec = '0;
        if (hit_l && (32'(ent_l) < RF_ENTRIES)) exp_vec[ent_l] = 1'b1;
    end

    assign diff      = CM_MATCH_RF_OUT_P0 ^ exp_vec;
    assign miss_err  = hit_l & ~(|(CM_MATCH_RF_OUT_P0 & exp_vec));
    assign extra_err = |(CM_MATCH_RF_OUT_P0 & ~exp_vec);
    assign mismatch  = vld_l & (|diff);

    // Clear beats a coincident mismatch for stored state only; the pulse is unaffected.
    always_comb begin
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        ff_vld_d  = ff_vld_q;
        ff_ent_d  = ff_ent_q;
        ff_type_d = ff_type_q;
        if (BIST_CM_CLEAR_RF_IN) begin
            sticky_d  = 1'b0;
            cnt_d     = '0;
            ff_vld_d  = 1'b0;
            ff_ent_d  = '0;
            ff_type_d = '0;
        end else if (mismatch) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (!ff_vld_q) begin
                ff_vld_d  = 1'b1;
                ff_ent_d  = ent_l;
                ff_type_d = {extra_err, miss_err};
            end
        end
    end

    always_ff @(posedge bist_clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_hit_q <= '0;
            for (int k = 0; k < CM_LATENCY; k++) pipe_ent_q[k] <= '0;
            fail_q    <= 1'b0;
            out_vld_q <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            ff_vld_q  <= 1'b0;
            ff_ent_q  <= '0;
            ff_type_q <= '0;
        end else begin
            pipe_vld_q[0] <= BIST_CM_EN_RF_IN & BIST_CM_MODE_RF_IN;
            pipe_hit_q[0] <= BIST_CM_EXP_HIT_RF_IN;
            pipe_ent_q[0] <= BIST_CM_EXP_ENTRY_RF_IN;
            for (int k = 1; k < CM_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_hit_q[k] <= pipe_hit_q[k-1];
                pipe_ent_q[k] <= pipe_ent_q[k-1];
            end
            fail_q    <= mismatch;
            out_vld_q <= vld_l;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            ff_vld_q  <= ff_vld_d;
            ff_ent_q  <= ff_ent_d;
            ff_type_q <= ff_type_d;
        end
    end

`ifdef BCAM_MBIST_FAIL_VEC_CAPTURE_EN
    logic [RF_ENTRIES-1:0] fvec_q;

    always_ff @(posedge bist_clk) begin
        if (rst || BIST_CM_CLEAR_RF_IN) begin
            fvec_q <= '0;
        end else if (mismatch && !ff_vld_q) begin
            fvec_q <= diff;
        end
    end

    assign BIST_CM_FAIL_VEC_RF_OUT = fvec_q;
`else
    assign BIST_CM_FAIL_VEC_RF_OUT = '0;
`endif

    assign BIST_CM_FAIL_RF_OUT             = fail_q;
    assign BIST_CM_FAIL_STICKY_RF_OUT      = sticky_q;
    assign BIST_CM_FAIL_CNT_RF_OUT         = cnt_q;
    assign BIST_CM_FIRST_FAIL_VLD_RF_OUT   = ff_vld_q;
    assign BIST_CM_FIRST_FAIL_ENTRY_RF_OUT = ff_ent_q;
    assign BIST_CM_FIRST_FAIL_TYPE_RF_OUT  = ff_type_q;
    assign BIST_CM_BUSY_RF_OUT             = (|pipe_vld_q) | out_vld_q;

endmodule

// File: doc/bcam_mbist_outhandler.md
Name: bcam_mbist_outhandler

Overview:
- Response-side companion to the BCAM MBIST input handler.
- Takes the CAM match vector returned by the array for each BIST compare, and builds the expected vector from the MBIST expectation issued with that compare.
- Aligns expectation and result through a latency pipeline and reports per-compare fail, sticky fail, saturating fail count and first-fail diagnostics back to the MBIST controller.

Parameters:
- RF_ENTRIES, 64, number of CAM entries (width of the match vector).
- CM_LATENCY, 2, cycles from compare issue to match vector valid at CM_MATCH_RF_OUT_P0; legal range 1..8.
- FAIL_CNT_W, 8, width of the saturating fail counter.
- ENTRY_AW, $clog2(RF_ENTRIES), derived entry index width; not overridden.

Ports:
- bist_clk  in  1  BIST clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- BIST_CM_MODE_RF_IN  in  1  compare mode active; issues are ignored when low.
- BIST_CM_EN_RF_IN  in  1  compare issued to the array this cycle.
- BIST_CM_EXP_HIT_RF_IN  in  1  1 = expect a single hit at the expected entry; 0 = expect all-miss (mask-enabled compare).
- BIST_CM_EXP_ENTRY_RF_IN  in  ENTRY_AW  expected hit entry.
- CM_MATCH_RF_OUT_P0  in  RF_ENTRIES  match vector from the array.
- BIST_CM_CLEAR_RF_IN  in  1  clears sticky, count and first-fail state.
- BIST_CM_FAIL_RF_OUT  out  1  one-cycle fail pulse per mismatching compare.
- BIST_CM_FAIL_STICKY_RF_OUT  out  1  sticky OR of all fails.
- BIST_CM_FAIL_CNT_RF_OUT  out  FAIL_CNT_W  saturating fail count.
- BIST_CM_FIRST_FAIL_VLD_RF_OUT  out  1  first-fail capture valid.
- BIST_CM_FIRST_FAIL_ENTRY_RF_OUT  out  ENTRY_AW  expected entry of the first failing compare.
- BIST_CM_FIRST_FAIL_TYPE_RF_OUT  out  2  failure type of the first fail: bit0 = expected hit missing, bit1 = unexpected hit present.
- BIST_CM_BUSY_RF_OUT  out  1  at least one compare is in flight.
- BIST_CM_FAIL_VEC_RF_OUT  out  RF_ENTRIES  first-fail difference vector (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, bist_clk. Reset rst is synchronous and active-high. All outputs and all pipeline state reset to 0.
- Issue capture: issue = BIST_CM_EN_RF_IN & BIST_CM_MODE_RF_IN. The pipeline stage 0 entry {vld = issue, exp_hit, exp_entry} is loaded every cycle.
- Pipeline: a CM_LATENCY-deep shift register. Stage CM_LATENCY-1 lines up with CM_MATCH_RF_OUT_P0 for that compare.
- Expected vector: exp_hit ? onehot(exp_entry) : 0. If exp_entry >= RF_ENTRIES, the expected vector is 0.
- Difference: diff = CM_MATCH_RF_OUT_P0 ^ expected.
  - miss_err = exp_hit & ~match[exp_entry].
  - extra_err = |(match & ~expected).
  - mismatch = vld & (|diff). The match vector is ignored when vld is 0.
- Fail pulse: BIST_CM_FAIL_RF_OUT is registered, so it asserts exactly CM_LATENCY+1 cycles after the issue cycle for one cycle. Back-to-back issues give independent, back-to-back pulses.
- Sticky fail: set on mismatch; held until clear or reset.
- Fail counter: +1 per mismatch; saturates at 2^FAIL_CNT_W-1 with no wrap.
- First-fail capture: on mismatch with FIRST_FAIL_VLD = 0, capture entry and type {extra_err, miss_err} and set VLD. Later fails do not overwrite the capture.
- Clear: sticky, count and first-fail state go to 0 on the next edge. The pipeline is not flushed.
  - If clear coincides with a mismatch, clear wins for stored state. The fail pulse still asserts.
- Busy: BUSY = OR of all pipeline vld bits, plus the output-stage vld. It drops the cycle after the last pulse opportunity.
- Reset mid-operation: pipeline flushed. In-flight compares produce no pulse after reset.
- Mode deassert with compares in flight: in-flight compares still complete and are checked. Only new issues are gated.

Optional Feature:
- Macro: BCAM_MBIST_FAIL_VEC_CAPTURE_EN.
- Defined: BIST_CM_FAIL_VEC_RF_OUT is a register capturing diff on the first-fail event. It is cleared by clear and reset, and held otherwise.
- Undefined: the port remains and is tied to 0. No RF_ENTRIES-wide storage is built.

Test Plan:
- Pass compare: CM_LATENCY=2. Issue exp_hit=1, entry=5; drive match=1<<5 at cycle+2 -> no fail pulse; sticky=0; count=0; BUSY high for 3 cycles.
- Missing hit: issue exp_hit=1, entry=10; match=0 -> fail pulse at issue+3; sticky=1; count=1; first entry=10; type=2'b01; fail vector (macro on) = 1<<10.
- Unexpected hit under mask: issue exp_hit=0; match=1<<63 -> fail pulse; type=2'b10. A second failing compare at entry 7 -> count=2; first entry unchanged.
- Back-to-back compares: issues on 4 consecutive cycles, 2nd and 4th mismatching -> pulses at issue+3 on the matching cycles only; count=2.
- Saturation and clear: FAIL_CNT_W=2, 5 failing compares -> count holds at 3. Clear coinciding with a 6th fail -> pulse asserts; count=0; sticky=0; VLD=0.
- Reset mid-flight: issue a failing compare, assert rst the next cycle -> no pulse; all outputs 0. Mode low with EN high -> no pulse and BUSY stays 0.
